// File: rtl/apb_wait_ram_slave.sv
// APB3 completer backed by a small word-addressed register RAM.
// Inserts WAIT_CYCLES wait states and flags misaligned / out-of-range accesses with pslverr.
module apb_wait_ram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [7:0]            err_count,
  output logic [1:0]            state_dbg
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  setup, start, enter_resp, commit;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_write, acc_err;
  logic [ADDR_WIDTH-3:0] acc_word;
  logic [IW-1:0]         acc_idx;

  assign state_dbg = state;

  always_comb begin
    setup = psel & ~penable;
    start = setup && (state == IDLE || state == RESP);
    // A zero-wait build enters RESP on the setup edge itself, so decode the
    // live bus in that case rather than the not-yet-latched copy.
    acc_addr  = start ? paddr : addr_q;
    acc_write = start ? pwrite : write_q;
    acc_word  = acc_addr[ADDR_WIDTH-1:2];
    acc_err   = (acc_addr[1:0] != 2'b00) || (acc_word >= WORD_LIMIT);
    acc_idx   = acc_addr[IW+1:2];

    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: ;
      ACCESS: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (cnt <= CW'(1)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
        commit    = psel & penable;
      end
      default: state_nxt = IDLE;
    endcase

    if (start) begin
      if (WAIT_CYCLES == 0) begin
        state_nxt  = RESP;
        enter_resp = 1'b1;
      end else begin
        state_nxt = ACCESS;
        cnt_nxt   = CW'(WAIT_CYCLES);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      err_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pready  <= enter_resp;
      pslverr <= enter_resp & acc_err;
      if (start) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
      if (enter_resp && !acc_write) prdata <= acc_err ? '0 : mem[acc_idx];
      // Side effects land only when the master completes the access phase.
      if (commit) begin
        if (acc_err) begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else if (write_q) begin
          mem[acc_idx] <= wdata_q;
        end
      end
    end
  end

endmodule
